// File: rtl/oled_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oled_spi_pkg
// Brief    : Shared types and constants for the OLED SPI receive path.
// Revision : 1.0 - initial release
// ============================================================================
package oled_spi_pkg;

   localparam int BITS_PER_BYTE = 8;
   localparam int CNT_W         = 16;

   // Receive controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_ABORT = 2'd2
   } rx_state_t;

   // One buffered byte together with its command/data flag
   typedef struct packed {
      logic       dc;
      logic [7:0] data;
   } rx_entry_t;

endpackage
`default_nettype wire

// File: rtl/oled_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : oled_rx_fifo
// Brief    : Small synchronous FIFO of received bytes. A push on a full
//            buffer is accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module oled_rx_fifo
   import oled_spi_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      i_push,
   input  rx_entry_t i_data,
   input  logic      i_pop,
   output rx_entry_t o_data,
   output logic      o_full,
   output logic      o_empty
);

   localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rx_entry_t         r_mem [DEPTH];
   logic [c_addr_w:0] r_wr_ptr;
   logic [c_addr_w:0] r_rd_ptr;
   logic              w_wr;
   logic              w_rd;

   // Pointers carry one extra wrap bit to tell full from empty
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                    (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
   assign w_wr    = i_push & (~o_full | i_pop);
   assign w_rd    = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr[c_addr_w-1:0]];

   // Storage and pointer update; storage is cleared so the head reads 0 after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_data;
            r_wr_ptr                      <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/oled_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : oled_spi_rx
// Brief    : Mode-0 SPI slave receiver for an OLED command/data stream.
//            Oversamples the SPI pins on sys_clk, assembles MSB-first bytes,
//            tags them with dc and buffers them for a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
module oled_spi_rx
   import oled_spi_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             spi_sck,
   input  logic             spi_mosi,
   input  logic             spi_cs,
   input  logic             spi_dc,
   output logic [7:0]       rx_byte,
   output logic             rx_dc,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             frame_err,
   output logic             overflow,
   output logic [CNT_W-1:0] byte_cnt
);

   localparam int                  c_bcnt_w   = $clog2(BITS_PER_BYTE);
   localparam logic [c_bcnt_w-1:0] c_last_bit = c_bcnt_w'(BITS_PER_BYTE - 1);

   logic [SYNC_STAGES-1:0]   r_sck_sync;
   logic [SYNC_STAGES-1:0]   r_mosi_sync;
   logic [SYNC_STAGES-1:0]   r_cs_sync;
   logic [SYNC_STAGES-1:0]   r_dc_sync;
   logic                     r_sck_prev;
   rx_state_t                r_state;
   logic [c_bcnt_w-1:0]      r_bit_cnt;
   logic [BITS_PER_BYTE-1:0] r_shift;
   logic                     r_push;
   rx_entry_t                r_push_entry;
   logic                     r_frame_err;
   logic                     r_overflow;
   logic [CNT_W-1:0]         r_byte_cnt;

   logic      w_sck;
   logic      w_mosi;
   logic      w_cs;
   logic      w_dc;
   logic      w_sck_rise;
   logic      w_pop;
   logic      w_full;
   logic      w_empty;
   logic      w_push_ok;
   rx_entry_t w_head;

   assign w_sck  = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs   = r_cs_sync[SYNC_STAGES-1];
   assign w_dc   = r_dc_sync[SYNC_STAGES-1];

   // Only sck edges inside an active frame count
   assign w_sck_rise = w_sck & ~r_sck_prev & ~w_cs & (r_state == ST_SHIFT);

   // Synchronise every SPI pin; cs idles deasserted (high)
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '1;
         r_dc_sync   <= '0;
         r_sck_prev  <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
         r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], spi_dc};
         r_sck_prev  <= w_sck;
      end
   end

   // Frame controller: shifts bits, issues a push on the 8th edge, aborts truncated bytes
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_push       <= 1'b0;
         r_push_entry <= '0;
         r_frame_err  <= 1'b0;
      end else begin
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_sck_rise) begin
            r_shift   <= {r_shift[BITS_PER_BYTE-2:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_last_bit) begin
               r_push       <= 1'b1;
               r_push_entry <= {w_dc, r_shift[BITS_PER_BYTE-2:0], w_mosi};
            end
         end
         case (r_state)
            ST_IDLE: begin
               if (!w_cs) begin
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_cs) begin
                  if (r_bit_cnt != '0) begin
                     r_state     <= ST_ABORT;
                     r_frame_err <= 1'b1;
                     r_bit_cnt   <= '0;
                     r_shift     <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_ABORT: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_pop     = rx_valid & rx_ready;
   assign w_push_ok = r_push & (~w_full | w_pop);

   // Accepted-byte counter and sticky drop flag
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_byte_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
         end
         if (r_push && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

   oled_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .i_push  (r_push),
      .i_data  (r_push_entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign rx_valid  = ~w_empty;
   assign rx_byte   = w_head.data;
   assign rx_dc     = w_head.dc;
   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;
   assign byte_cnt  = r_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_spi_rx
// Brief    : Self-checking bench for oled_spi_rx; a behavioural SPI master
//            drives the pins and observed bytes are compared with queues of
//            what the master sent.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oled_spi_rx;

   localparam int FIFO_DEPTH  = 4;
   localparam int SYNC_STAGES = 2;
   localparam int MAX_LAT     = SYNC_STAGES + 3;

   logic        sys_clk  = 1'b0;
   logic        sys_rst  = 1'b1;
   logic        spi_sck  = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_cs   = 1'b1;
   logic        spi_dc   = 1'b0;
   logic        rx_ready = 1'b0;
   logic [7:0]  rx_byte;
   logic        rx_dc;
   logic        rx_valid;
   logic        frame_err;
   logic        overflow;
   logic [15:0] byte_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Observation state, written only by the monitor below
   logic [8:0] got_q[$];
   int         fe_pulses  = 0;
   int         fe_cycles  = 0;
   int         stall_viol = 0;
   int         lat_max    = 0;
   int         sck_age    = 0;
   logic       sck_prev   = 1'b0;
   logic       fe_prev    = 1'b0;
   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [8:0] prev_head  = '0;

   always #5 sys_clk = ~sys_clk;

   oled_spi_rx #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .spi_sck   (spi_sck),
      .spi_mosi  (spi_mosi),
      .spi_cs    (spi_cs),
      .spi_dc    (spi_dc),
      .rx_byte   (rx_byte),
      .rx_dc     (rx_dc),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overflow  (overflow),
      .byte_cnt  (byte_cnt)
   );

   // Monitor on the falling edge: inputs change at posedge+2, so values seen
   // here are the ones the next rising edge acts on.
   always @(negedge sys_clk) begin
      if (spi_sck && !sck_prev) sck_age = 0;
      else                      sck_age = sck_age + 1;
      sck_prev = spi_sck;
      if (!sys_rst) begin
         if (rx_valid && !prev_valid && sck_age > lat_max) lat_max = sck_age;
         if (frame_err) fe_cycles = fe_cycles + 1;
         if (frame_err && !fe_prev) fe_pulses = fe_pulses + 1;
         if (prev_valid && !prev_ready && rx_valid && ({rx_dc, rx_byte} !== prev_head))
            stall_viol = stall_viol + 1;
         if (rx_valid && rx_ready) got_q.push_back({rx_dc, rx_byte});
      end
      fe_prev    = frame_err;
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_head  = {rx_dc, rx_byte};
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
      end
   endtask

   task automatic do_reset();
      sys_rst  = 1'b1;
      spi_cs   = 1'b1;
      spi_sck  = 1'b0;
      spi_mosi = 1'b0;
      rx_ready = 1'b0;
      tick(3);
      sys_rst = 1'b0;
      tick(2);
   endtask

   // One SPI bit; with pop_sync the consumer pops exactly in the push cycle
   task automatic send_bit(input logic b, input logic dc, input bit pop_sync);
      spi_mosi = b;
      spi_dc   = dc;
      tick($urandom_range(3, 6));
      spi_sck = 1'b1;
      if (pop_sync) begin
         tick(SYNC_STAGES + 1);
         rx_ready = 1'b1;
         tick(1);
         rx_ready = 1'b0;
         tick(1);
      end else begin
         tick($urandom_range(3, 6));
      end
      spi_sck = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] d, input int n, input logic dc);
      for (int i = 0; i < n; i++) send_bit(d[7-i], dc, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic dc, input bit pop_sync);
      for (int i = 0; i < 8; i++) send_bit(d[7-i], dc, pop_sync && (i == 7));
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      tick(4);
   endtask

   task automatic cs_high();
      tick(3);
      spi_cs = 1'b1;
      tick(4);
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      tick(2);
      n_cmp++; if (rx_valid !== 1'b0)   begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      n_cmp++; if (frame_err !== 1'b0)  begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_cmp++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      n_cmp++; if (byte_cnt !== 16'd0)  begin n_err++; $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end
      n_cmp++; if (rx_byte !== 8'h00)   begin n_err++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
      n_cmp++; if (rx_dc !== 1'b0)      begin n_err++; $display("FAIL reset_rx_dc: got %b want 0", rx_dc); end
      sys_rst = 1'b0;
      tick(2);
   endtask

   task automatic test_single();
      int base, fe0;
      do_reset();
      rx_ready = 1'b1;
      base = got_q.size();
      fe0  = fe_pulses;
      cs_low();
      send_byte(8'hAE, 1'b0, 1'b0);
      cs_high();
      tick(10);
      n_cmp++; if (got_q.size() - base !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", got_q.size() - base); end
      if (got_q.size() > base) begin
         n_cmp++; if (got_q[base] !== {1'b0, 8'hAE}) begin n_err++; $display("FAIL single_byte: got %h want 0ae", got_q[base]); end
      end
      n_cmp++; if (byte_cnt !== 16'd1)      begin n_err++; $display("FAIL single_byte_cnt: got %0d want 1", byte_cnt); end
      n_cmp++; if (fe_pulses - fe0 !== 0)   begin n_err++; $display("FAIL single_frame_err: got %0d pulses want 0", fe_pulses - fe0); end
      n_cmp++; if (rx_valid !== 1'b0)       begin n_err++; $display("FAIL single_drained: got %b want 0", rx_valid); end
   endtask

   task automatic test_stream();
      logic [7:0] exp [3];
      int base;
      exp[0] = 8'h3C; exp[1] = 8'h00; exp[2] = 8'hFF;
      do_reset();
      rx_ready = 1'b1;
      base = got_q.size();
      cs_low();
      for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b1, 1'b0);
      cs_high();
      tick(10);
      n_cmp++; if (got_q.size() - base !== 3) begin n_err++; $display("FAIL stream_count: got %0d want 3", got_q.size() - base); end
      for (int i = 0; i < 3; i++) begin
         if (base + i < got_q.size()) begin
            n_cmp++; if (got_q[base+i] !== {1'b1, exp[i]}) begin n_err++; $display("FAIL stream_byte%0d: got %h want %h", i, got_q[base+i], {1'b1, exp[i]}); end
         end
      end
      n_cmp++; if (byte_cnt !== 16'd3) begin n_err++; $display("FAIL stream_byte_cnt: got %0d want 3", byte_cnt); end
   endtask

   task automatic test_frame_err();
      int base, fe0, fc0;
      do_reset();
      rx_ready = 1'b1;
      base = got_q.size();
      fe0  = fe_pulses;
      fc0  = fe_cycles;
      cs_low();
      send_bits(8'b1011_0000, 5, 1'b0);
      cs_high();
      tick(6);
      n_cmp++; if (fe_pulses - fe0 !== 1)   begin n_err++; $display("FAIL trunc_pulses: got %0d want 1", fe_pulses - fe0); end
      n_cmp++; if (fe_cycles - fc0 !== 1)   begin n_err++; $display("FAIL trunc_pulse_len: got %0d want 1", fe_cycles - fc0); end
      n_cmp++; if (got_q.size() - base !== 0) begin n_err++; $display("FAIL trunc_no_byte: got %0d want 0", got_q.size() - base); end
      n_cmp++; if (byte_cnt !== 16'd0)      begin n_err++; $display("FAIL trunc_byte_cnt: got %0d want 0", byte_cnt); end
      // empty frame: cs toggles with no bits, must not flag an error
      cs_low();
      cs_high();
      tick(4);
      n_cmp++; if (fe_pulses - fe0 !== 1)   begin n_err++; $display("FAIL empty_frame_err: got %0d pulses want 1", fe_pulses - fe0); end
      cs_low();
      send_byte(8'h81, 1'b0, 1'b0);
      cs_high();
      tick(10);
      n_cmp++; if (got_q.size() - base !== 1) begin n_err++; $display("FAIL after_trunc_count: got %0d want 1", got_q.size() - base); end
      if (got_q.size() > base) begin
         n_cmp++; if (got_q[base] !== {1'b0, 8'h81}) begin n_err++; $display("FAIL after_trunc_byte: got %h want 081", got_q[base]); end
      end
      n_cmp++; if (byte_cnt !== 16'd1) begin n_err++; $display("FAIL after_trunc_byte_cnt: got %0d want 1", byte_cnt); end
   endtask

   task automatic test_overflow();
      int base, sv0;
      do_reset();
      base = got_q.size();
      sv0  = stall_viol;
      cs_low();
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 1'b0);
      cs_high();
      tick(10);
      n_cmp++; if (overflow !== 1'b1)    begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      n_cmp++; if (byte_cnt !== 16'd4)   begin n_err++; $display("FAIL ovf_byte_cnt: got %0d want 4", byte_cnt); end
      n_cmp++; if (rx_byte !== 8'h01)    begin n_err++; $display("FAIL ovf_head: got %h want 01", rx_byte); end
      n_cmp++; if (stall_viol - sv0 !== 0) begin n_err++; $display("FAIL ovf_stall_hold: got %0d changes want 0", stall_viol - sv0); end
      rx_ready = 1'b1;
      tick(10);
      rx_ready = 1'b0;
      n_cmp++; if (got_q.size() - base !== 4) begin n_err++; $display("FAIL ovf_drain_count: got %0d want 4", got_q.size() - base); end
      for (int i = 0; i < 4; i++) begin
         if (base + i < got_q.size()) begin
            n_cmp++; if (got_q[base+i] !== {1'b0, 8'(i + 1)}) begin n_err++; $display("FAIL ovf_drain%0d: got %h want %h", i, got_q[base+i], {1'b0, 8'(i + 1)}); end
         end
      end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [8:0] exp [5];
      int base;
      for (int i = 0; i < 5; i++) exp[i] = {1'($urandom_range(0, 1)), 8'(8'h11 + i)};
      do_reset();
      base = got_q.size();
      cs_low();
      for (int i = 0; i < 4; i++) send_byte(exp[i][7:0], exp[i][8], 1'b0);
      send_byte(exp[4][7:0], exp[4][8], 1'b1);
      cs_high();
      tick(6);
      n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL fullpp_overflow: got %b want 0", overflow); end
      n_cmp++; if (byte_cnt !== 16'd5) begin n_err++; $display("FAIL fullpp_byte_cnt: got %0d want 5", byte_cnt); end
      n_cmp++; if (got_q.size() - base !== 1) begin n_err++; $display("FAIL fullpp_pop: got %0d want 1", got_q.size() - base); end
      rx_ready = 1'b1;
      tick(10);
      rx_ready = 1'b0;
      n_cmp++; if (got_q.size() - base !== 5) begin n_err++; $display("FAIL fullpp_count: got %0d want 5", got_q.size() - base); end
      for (int i = 0; i < 5; i++) begin
         if (base + i < got_q.size()) begin
            n_cmp++; if (got_q[base+i] !== exp[i]) begin n_err++; $display("FAIL fullpp_byte%0d: got %h want %h", i, got_q[base+i], exp[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int base, fe0;
      do_reset();
      cs_low();
      send_byte(8'h5A, 1'b1, 1'b0);
      send_bits(8'hE0, 3, 1'b1);
      tick(1);
      sys_rst = 1'b1;
      #1;
      n_cmp++; if (rx_valid !== 1'b0)  begin n_err++; $display("FAIL midrst_rx_valid: got %b want 0", rx_valid); end
      n_cmp++; if (rx_byte !== 8'h00)  begin n_err++; $display("FAIL midrst_rx_byte: got %h want 00", rx_byte); end
      n_cmp++; if (rx_dc !== 1'b0)     begin n_err++; $display("FAIL midrst_rx_dc: got %b want 0", rx_dc); end
      n_cmp++; if (byte_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_byte_cnt: got %0d want 0", byte_cnt); end
      n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
      spi_cs = 1'b1;
      tick(3);
      sys_rst = 1'b0;
      fe0 = fe_pulses;
      tick(4);
      rx_ready = 1'b1;
      base = got_q.size();
      cs_low();
      send_byte(8'hA5, 1'b0, 1'b0);
      cs_high();
      tick(10);
      n_cmp++; if (fe_pulses - fe0 !== 0) begin n_err++; $display("FAIL midrst_frame_err: got %0d pulses want 0", fe_pulses - fe0); end
      n_cmp++; if (got_q.size() - base !== 1) begin n_err++; $display("FAIL midrst_count: got %0d want 1", got_q.size() - base); end
      if (got_q.size() > base) begin
         n_cmp++; if (got_q[base] !== {1'b0, 8'hA5}) begin n_err++; $display("FAIL midrst_byte: got %h want 0a5", got_q[base]); end
      end
      n_cmp++; if (byte_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_byte_cnt: got %0d want 1", byte_cnt); end
   endtask

   task automatic test_wrap();
      logic [7:0] d;
      logic       dc;
      int         base;
      d  = 8'($urandom);
      dc = 1'($urandom_range(0, 1));
      do_reset();
      rx_ready = 1'b1;
      force dut.r_byte_cnt = 16'hFFFF;
      tick(1);
      release dut.r_byte_cnt;
      tick(1);
      n_cmp++; if (byte_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", byte_cnt); end
      base = got_q.size();
      cs_low();
      send_byte(d, dc, 1'b0);
      cs_high();
      tick(10);
      n_cmp++; if (byte_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_byte_cnt: got %h want 0000", byte_cnt); end
      n_cmp++; if (got_q.size() - base !== 1) begin n_err++; $display("FAIL wrap_count: got %0d want 1", got_q.size() - base); end
      if (got_q.size() > base) begin
         n_cmp++; if (got_q[base] !== {dc, d}) begin n_err++; $display("FAIL wrap_byte: got %h want %h", got_q[base], {dc, d}); end
      end
   endtask

   task automatic test_random();
      logic [8:0] exp_q[$];
      int         base, fe0, fc0, sv0, fe_exp;
      bit         done;
      do_reset();
      base   = got_q.size();
      fe0    = fe_pulses;
      fc0    = fe_cycles;
      sv0    = stall_viol;
      fe_exp = 0;
      done   = 1'b0;
      fork
         begin
            while (!done) begin
               rx_ready = 1'($urandom_range(0, 1));
               tick(1);
            end
         end
         begin
            for (int t = 0; t < 6; t++) begin
               cs_low();
               for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                  logic [7:0] d;
                  logic       dc;
                  d  = 8'($urandom);
                  dc = 1'($urandom_range(0, 1));
                  send_byte(d, dc, 1'b0);
                  exp_q.push_back({dc, d});
               end
               if ($urandom_range(0, 2) == 0) begin
                  send_bits(8'($urandom), $urandom_range(1, 7), 1'($urandom_range(0, 1)));
                  fe_exp++;
               end
               cs_high();
            end
            tick(20);
            done = 1'b1;
         end
      join
      rx_ready = 1'b1;
      tick(10);
      rx_ready = 1'b0;
      n_cmp++; if (got_q.size() - base !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < got_q.size()) begin
            n_cmp++; if (got_q[base+i] !== exp_q[i]) begin n_err++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[base+i], exp_q[i]); end
         end
      end
      n_cmp++; if (fe_pulses - fe0 !== fe_exp) begin n_err++; $display("FAIL rand_frame_err: got %0d want %0d", fe_pulses - fe0, fe_exp); end
      n_cmp++; if (fe_cycles - fc0 !== fe_exp) begin n_err++; $display("FAIL rand_frame_err_len: got %0d want %0d", fe_cycles - fc0, fe_exp); end
      n_cmp++; if (byte_cnt !== 16'(exp_q.size())) begin n_err++; $display("FAIL rand_byte_cnt: got %0d want %0d", byte_cnt, exp_q.size()); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rand_overflow: got %b want 0", overflow); end
      n_cmp++; if (stall_viol - sv0 !== 0) begin n_err++; $display("FAIL rand_stall_hold: got %0d changes want 0", stall_viol - sv0); end
   endtask

   task automatic test_latency();
      n_cmp++;
      if (lat_max < 1 || lat_max > MAX_LAT) begin
         n_err++;
         $display("FAIL latency: got %0d cycles want 1..%0d", lat_max, MAX_LAT);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_frame_err();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      test_wrap();
      test_random();
      test_latency();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/oled_spi_rx.md
OLED_SPI_RX -- requirements
Module: oled_spi_rx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the received-byte buffer depth (power of two, 2..16).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth on every SPI input (2..3).
REQ-003 The block SHALL have port sys_clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port spi_sck, input, 1 bit: SPI clock from the OLED driver, idle low, mode 0.
REQ-006 The block SHALL have port spi_mosi, input, 1 bit: serial data, MSB first, sampled on spi_sck rising edge.
REQ-007 The block SHALL have port spi_cs, input, 1 bit: chip select, active-low.
REQ-008 The block SHALL have port spi_dc, input, 1 bit: 0 = command byte, 1 = display-data byte.
REQ-009 The block SHALL have port rx_byte, output, 8 bits: head-of-buffer byte.
REQ-010 The block SHALL have port rx_dc, output, 1 bit: dc flag of the head byte.
REQ-011 The block SHALL have port rx_valid, output, 1 bit: head byte available.
REQ-012 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the head byte when rx_valid and rx_ready are both high.
REQ-013 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a truncated byte.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky; a byte was dropped.
REQ-015 The block SHALL have port byte_cnt, output, 16 bits: count of bytes written into the buffer.

Function
REQ-016 spi_sck, spi_mosi, spi_cs and spi_dc SHALL each pass through SYNC_STAGES flip-flops before use; the inputs are stable from SYNC_STAGES cycles before to SYNC_STAGES cycles after each sck rising edge, and sck high/low times are at least 2 sys_clk periods each.
REQ-017 A sck rising edge SHALL be detected as synced sck = 1 with previous synced sck = 0, and is ignored while synced cs = 1.
REQ-018 On each detected edge, mosi SHALL shift into an 8-bit register MSB first, and a 3-bit bit counter SHALL increment, wrapping 7 -> 0.
REQ-019 On the 8th edge, the assembled byte together with synced dc sampled on that edge SHALL be pushed into the buffer in the next cycle.
REQ-020 rx_valid SHALL rise no later than SYNC_STAGES+3 sys_clk cycles after the 8th sck rising edge reaches the pin.
REQ-021 rx_byte/rx_dc SHALL be held stable while rx_valid = 1 and rx_ready = 0.
REQ-022 A synced cs rising edge while the bit counter is nonzero SHALL discard the partial byte, clear the counter and pulse frame_err for exactly one cycle.
REQ-023 A synced cs rising edge while the bit counter is 0 SHALL have no effect.
REQ-024 A push while the buffer is full and no pop occurs in the same cycle SHALL drop the byte, set overflow, and leave byte_cnt unchanged.
REQ-025 A push and pop in the same cycle on a full buffer SHALL both succeed.
REQ-026 A push and pop in the same cycle on an empty buffer SHALL be impossible, since rx_valid is 0 on an empty buffer.
REQ-027 byte_cnt SHALL increment once per accepted push and wrap 65535 -> 0.
REQ-028 Reads and writes SHALL go through an internal controller with states IDLE (cs high), SHIFT (cs low, counting bits) and ABORT (one cycle, frame_err); transitions IDLE->SHIFT on cs low, SHIFT->IDLE on cs high with counter 0, SHIFT->ABORT on cs high with counter nonzero, ABORT->IDLE unconditionally.

Reset
REQ-029 On sys_rst high, the block SHALL immediately set all of the following to 0: rx_valid, frame_err, overflow, byte_cnt, rx_byte, rx_dc, buffer pointers, bit counter and shift register.
REQ-030 On sys_rst high, the synchronisers SHALL reset to sck = 0, cs = 1, mosi = 0 and dc = 0, and the controller SHALL enter IDLE.
REQ-031 Reset asserted mid-byte SHALL discard the partial byte with no frame_err pulse.
REQ-032 The first byte after reset release SHALL start at the next cs falling edge.

Structure
REQ-033 Package oled_spi_pkg SHALL hold the state enumeration, the buffer-entry record {dc, byte[7:0]} and the constants BITS_PER_BYTE = 8 and CNT_W = 16.
REQ-034 The buffer SHALL be a separate sub-module, oled_rx_fifo, with push/pop/full/empty ports, parameterised by FIFO_DEPTH.

Verification
REQ-035 The bench SHALL cover: cs low, send 0xAE with dc = 0, cs high -> one rx_valid with rx_byte = 0xAE, rx_dc = 0, byte_cnt = 1, frame_err = 0.
REQ-036 The bench SHALL cover: cs low, send 0x3C, 0x00, 0xFF with dc = 1 and rx_ready = 1 -> three bytes in order with rx_dc = 1, byte_cnt = 3.
REQ-037 The bench SHALL cover: cs low, 5 bits then cs high -> frame_err pulse of 1 cycle, no rx_valid; next full byte 0x81 is received intact.
REQ-038 The bench SHALL cover: rx_ready = 0, send 5 bytes 0x01..0x05 -> overflow = 1, byte_cnt = 4; draining yields 0x01..0x04 only.
REQ-039 The bench SHALL cover: sys_rst pulsed after 3 bits of a byte -> all outputs 0; a following byte 0xA5 is received correctly with byte_cnt = 1.
REQ-040 The bench SHALL cover: byte_cnt preloaded to 65535 via 65535 byte transfers (or a forced value), one more byte -> byte_cnt = 0.
